// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encoding and
// the register-source code used by the M/W result muxes.
// Imported by the interface, the calculator and the top.
package mdu_unit_pkg;

   typedef enum logic [3:0] {
      MDU_OP_NOP   = 4'd0,
      MDU_OP_MULT  = 4'd1,
      MDU_OP_MULTU = 4'd2,
      MDU_OP_DIV   = 4'd3,
      MDU_OP_DIVU  = 4'd4,
      MDU_OP_MFHI  = 4'd5,
      MDU_OP_MFLO  = 4'd6,
      MDU_OP_MTHI  = 4'd7,
      MDU_OP_MTLO  = 4'd8
   } mdu_op_e;

   // Register-source select for the M/W stage result mux: MFHI/MFLO result
   localparam logic [2:0] RS_MDU = 3'd5;

   // True for ops that occupy the unit for several cycles
   function automatic logic is_multicycle(input mdu_op_e op);
      return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
             (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// E-stage <-> MDU connection: request side (start/op/operands) and
// result side (busy, HI/LO, MFHI/MFLO read value).
// master = E-stage controller/datapath, slave = the MDU.
interface mdu_unit_if;
   import mdu_unit_pkg::*;

   logic        start;
   mdu_op_e     mdu_op;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mdu_out;

   modport master (output start, mdu_op, srcA, srcB,
                   input  busy, hi, lo, mdu_out);

   modport slave  (input  start, mdu_op, srcA, srcB,
                   output busy, hi, lo, mdu_out);
endinterface

// File: rtl/mdu_calc.sv
// Purely combinational multiply/divide datapath with the divide special cases.
// Latency 0; no handshake - the caller decides when the result is captured.
// Kept apart so an iterative divider can replace it without touching commit logic.
module mdu_calc
   import mdu_unit_pkg::*;
(
   input  mdu_op_e     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] cur_hi,
   input  logic [31:0] cur_lo,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] div_b;
   logic [31:0] div_bs;
   logic        div_zero;
   logic        div_ovf;
   logic [31:0] q_s;
   logic [31:0] r_s;
   logic [31:0] q_u;
   logic [31:0] r_u;

   // Compute every candidate result, then select by opcode
   always_comb begin
      prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_u   = {32'd0, a} * {32'd0, b};
      div_zero = (b == 32'd0);
      div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      // Divisors are forced to 1 in the special cases so the divider never
      // sees a zero divisor or the overflowing signed pair.
      div_b    = div_zero ? 32'd1 : b;
      div_bs   = (div_zero || div_ovf) ? 32'd1 : b;
      q_s      = $signed(a) / $signed(div_bs);
      r_s      = $signed(a) % $signed(div_bs);
      q_u      = a / div_b;
      r_u      = a % div_b;

      res_hi = cur_hi;
      res_lo = cur_lo;
      case (op)
         MDU_OP_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         MDU_OP_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         MDU_OP_DIV: begin
            if (div_zero) begin
               res_hi = cur_hi;
               res_lo = cur_lo;
            end else if (div_ovf) begin
               res_hi = 32'd0;
               res_lo = 32'h8000_0000;
            end else begin
               res_hi = r_s;
               res_lo = q_s;
            end
         end
         MDU_OP_DIVU: begin
            if (!div_zero) begin
               res_hi = r_u;
               res_lo = q_u;
            end
         end
         default: begin
            res_hi = cur_hi;
            res_lo = cur_lo;
         end
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit owning HI/LO; result captured on accept, committed after N cycles.
// Latency MULT_CYCLES / DIV_CYCLES; MTHI/MTLO take effect at the accept edge.
// Backpressure: busy high while counting; start during busy is dropped.
module mdu_unit
   import mdu_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic        clk,
   input  logic        reset,
   mdu_unit_if.slave   bus
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      pend_hi_q, pend_hi_d;
   logic [31:0]      pend_lo_q, pend_lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      calc_hi;
   logic [31:0]      calc_lo;
   logic             busy;

   mdu_calc u_calc (
      .op     (bus.mdu_op),
      .a      (bus.srcA),
      .b      (bus.srcB),
      .cur_hi (hi_q),
      .cur_lo (lo_q),
      .res_hi (calc_hi),
      .res_lo (calc_lo)
   );

   assign busy = (cnt_q != '0);

   // Accept, count-down and commit of HI/LO
   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      cnt_d     = cnt_q;
      if (busy) begin
         // Requests arriving while busy are ignored entirely
         if (cnt_q == CNT_ONE) begin
            hi_d  = pend_hi_q;
            lo_d  = pend_lo_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end else if (bus.start) begin
         case (bus.mdu_op)
            MDU_OP_MULT, MDU_OP_MULTU: begin
               pend_hi_d = calc_hi;
               pend_lo_d = calc_lo;
               cnt_d     = MULT_LOAD;
            end
            MDU_OP_DIV, MDU_OP_DIVU: begin
               pend_hi_d = calc_hi;
               pend_lo_d = calc_lo;
               cnt_d     = DIV_LOAD;
            end
            MDU_OP_MTHI: hi_d = bus.srcA;
            MDU_OP_MTLO: lo_d = bus.srcA;
            default: ;
         endcase
      end
   end

   // State registers; reset discards any in-flight operation
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         cnt_q     <= '0;
      end else begin
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         cnt_q     <= cnt_d;
      end
   end

   // MFHI/MFLO read value, not forwarded from a same-cycle commit
   always_comb begin
      bus.mdu_out = 32'd0;
      if (bus.mdu_op == MDU_OP_MFHI) bus.mdu_out = hi_q;
      else if (bus.mdu_op == MDU_OP_MFLO) bus.mdu_out = lo_q;
   end

   assign bus.busy = busy;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed corner cases plus random ops
// compared against a 64-bit arithmetic reference model of HI/LO.
module tb_mdu_unit;
   import mdu_unit_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] m_hi, m_lo;

   mdu_unit_if bus ();

   mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: architectural HI/LO after the op completes
   task automatic model(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
      longint p, sa, sb, q, r;
      logic [63:0] v;
      case (op)
         MDU_OP_MULT: begin
            p = longint'($signed(a)) * longint'($signed(b));
            v = p; m_hi = v[63:32]; m_lo = v[31:0];
         end
         MDU_OP_MULTU: begin
            p = longint'({32'd0, a}) * longint'({32'd0, b});
            v = p; m_hi = v[63:32]; m_lo = v[31:0];
         end
         MDU_OP_DIV: if (b != 0) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            q = sa / sb; r = sa % sb;
            v = q; m_lo = v[31:0];
            v = r; m_hi = v[31:0];
         end
         MDU_OP_DIVU: if (b != 0) begin
            sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
            q = sa / sb; r = sa % sb;
            v = q; m_lo = v[31:0];
            v = r; m_hi = v[31:0];
         end
         MDU_OP_MTHI: m_hi = a;
         MDU_OP_MTLO: m_lo = a;
         default: ;
      endcase
   endtask

   // One-cycle request; returns at the negedge after the accept edge
   task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start = 1'b1; bus.mdu_op = op; bus.srcA = a; bus.srcB = b;
      @(negedge clk);
      bus.start = 1'b0; bus.mdu_op = MDU_OP_NOP;
   endtask

   // Issue, measure busy length, confirm no early commit, compare HI/LO
   task automatic run_op(input string tag, input mdu_op_e op,
                         input logic [31:0] a, input logic [31:0] b);
      int n, exp_n;
      logic early;
      logic [31:0] hi0, lo0;
      hi0 = m_hi; lo0 = m_lo;
      issue(op, a, b);
      n = 0; early = 1'b0;
      while (bus.busy === 1'b1 && n < 100) begin
         if (bus.hi !== hi0 || bus.lo !== lo0) early = 1'b1;
         n++;
         @(negedge clk);
      end
      exp_n = (op == MDU_OP_MULT || op == MDU_OP_MULTU) ? MULT_N :
              (op == MDU_OP_DIV  || op == MDU_OP_DIVU)  ? DIV_N  : 0;
      model(op, a, b);
      check({tag, "_busy_len"}, 32'(n), 32'(exp_n));
      check({tag, "_early"}, 32'(early), 32'd0);
      check({tag, "_hi"}, bus.hi, m_hi);
      check({tag, "_lo"}, bus.lo, m_lo);
   endtask

   mdu_op_e ops [6] = '{MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU,
                        MDU_OP_MTHI, MDU_OP_MTLO};

   initial begin
      int n;
      logic [31:0] ra, rb;
      mdu_op_e rop;

      bus.start = 1'b0; bus.mdu_op = MDU_OP_NOP; bus.srcA = '0; bus.srcB = '0;
      rst_n = 1'b0; m_hi = '0; m_lo = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset asserted in the middle of a MULT
      issue(MDU_OP_MULT, 32'd3, 32'd4);
      @(negedge clk);
      check("midrst_busy_pre", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_hi", bus.hi, 32'd0);
      check("midrst_lo", bus.lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("postrst_busy", 32'(bus.busy), 32'd0);
      check("postrst_hi", bus.hi, 32'd0);
      check("postrst_lo", bus.lo, 32'd0);

      // Directed arithmetic corners
      run_op("mult_neg", MDU_OP_MULT, 32'hFFFF_FFFF, 32'd2);
      check("mult_neg_hi_k", bus.hi, 32'hFFFF_FFFF);
      check("mult_neg_lo_k", bus.lo, 32'hFFFF_FFFE);
      run_op("multu", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      check("multu_hi_k", bus.hi, 32'h0000_0001);
      check("multu_lo_k", bus.lo, 32'hFFFF_FFFE);
      run_op("div_neg", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
      check("div_neg_lo_k", bus.lo, 32'hFFFF_FFFD);
      check("div_neg_hi_k", bus.hi, 32'hFFFF_FFFF);
      run_op("divu", MDU_OP_DIVU, 32'd7, 32'd2);
      check("divu_lo_k", bus.lo, 32'd3);
      check("divu_hi_k", bus.hi, 32'd1);
      run_op("mthi", MDU_OP_MTHI, 32'h11, 32'd0);
      run_op("mtlo", MDU_OP_MTLO, 32'h22, 32'd0);
      run_op("div0", MDU_OP_DIV, 32'd5, 32'd0);
      check("div0_hi_k", bus.hi, 32'h11);
      check("div0_lo_k", bus.lo, 32'h22);
      run_op("div_ovf", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div_ovf_lo_k", bus.lo, 32'h8000_0000);
      check("div_ovf_hi_k", bus.hi, 32'd0);

      // MULT request while a DIV is in flight must be dropped
      ra = 32'd1000; rb = 32'd7;
      issue(MDU_OP_DIV, ra, rb);
      repeat (2) @(negedge clk);
      bus.start = 1'b1; bus.mdu_op = MDU_OP_MULT;
      bus.srcA = 32'h1234_5678; bus.srcB = 32'h9ABC_DEF0;
      @(negedge clk);
      bus.start = 1'b0; bus.mdu_op = MDU_OP_NOP;
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      model(MDU_OP_DIV, ra, rb);
      check("ign_busy_len", 32'(n + 3), 32'(DIV_N));
      check("ign_hi", bus.hi, m_hi);
      check("ign_lo", bus.lo, m_lo);
      bus.start = 1'b1; bus.mdu_op = MDU_OP_MFHI;
      #1 check("ign_mfhi", bus.mdu_out, m_hi);
      bus.mdu_op = MDU_OP_MFLO;
      #1 check("ign_mflo", bus.mdu_out, m_lo);
      bus.mdu_op = MDU_OP_NOP;
      #1 check("nop_out", bus.mdu_out, 32'd0);
      bus.start = 1'b0;
      run_op("mtlo_abcd", MDU_OP_MTLO, 32'h0000_ABCD, 32'd0);
      check("mtlo_busy", 32'(bus.busy), 32'd0);

      // Randomised operations against the model
      for (int i = 0; i < 30; i++) begin
         rop = ops[$urandom_range(0, 5)];
         ra  = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = $urandom_range(1, 20);
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         run_op($sformatf("rnd%0d", i), rop, ra, rb);
         bus.mdu_op = ($urandom_range(0, 1) == 0) ? MDU_OP_MFHI : MDU_OP_MFLO;
         #1 check($sformatf("rnd%0d_mfx", i), bus.mdu_out,
                  (bus.mdu_op == MDU_OP_MFHI) ? m_hi : m_lo);
         bus.mdu_op = MDU_OP_NOP;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
